// File: rtl/player_bullet_ctl.sv
// Player bullet controller: launches one bullet from the tank, moves it once per
// frame, terminates on obstacle, target hit or screen edge, then enforces a cooldown.
module player_bullet_ctl #(
  parameter int SPEED           = 4,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int X_MAX           = 799,
  parameter int Y_MAX           = 599,
  parameter int HIT_HALF        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       fire,
  input  logic [1:0] tank_dir,
  input  logic [9:0] xpos_tank,
  input  logic [9:0] ypos_tank,
  input  logic [9:0] xpos_target,
  input  logic [9:0] ypos_target,
  input  logic       obstacle_hit,
  output logic [9:0] xpos_bullet,
  output logic [9:0] ypos_bullet,
  output logic [2:0] direction_out,
  output logic       target_hit,
  output logic       busy
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FLY      = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [10:0] SPD = 11'(SPEED);
  localparam logic [10:0] XM  = 11'(X_MAX);
  localparam logic [10:0] YM  = 11'(Y_MAX);
  localparam logic [10:0] HH  = 11'(HIT_HALF);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          vsync_d;
  logic          frame_tick;
  logic [10:0]   xb, yb, dx, dy, nx, ny;
  logic          oob, overlap, hit_now, term;

  assign frame_tick = vsync & ~vsync_d;
  assign xb = {1'b0, xpos_bullet};
  assign yb = {1'b0, ypos_bullet};

  // distances are taken as |a-b| in 11 bits so nothing wraps
  assign dx = (xb >= {1'b0, xpos_target}) ? xb - {1'b0, xpos_target} : {1'b0, xpos_target} - xb;
  assign dy = (yb >= {1'b0, ypos_target}) ? yb - {1'b0, ypos_target} : {1'b0, ypos_target} - yb;
  assign overlap = (dx <= HH) && (dy <= HH);

  always_comb begin
    oob = 1'b0;
    nx  = xb;
    ny  = yb;
    case (direction_out)
      3'd1: begin oob = yb < SPD;      ny = yb - SPD; end
      3'd2: begin oob = yb + SPD > YM; ny = yb + SPD; end
      3'd3: begin oob = xb + SPD > XM; nx = xb + SPD; end
      3'd4: begin oob = xb < SPD;      nx = xb - SPD; end
      default: ;
    endcase
  end

  // obstacle outranks target, which outranks motion
  assign hit_now = (state == FLY) && !obstacle_hit && overlap;
  assign term    = (state == FLY) && (obstacle_hit || overlap || (frame_tick && oob));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      vsync_d       <= 1'b0;
      xpos_bullet   <= '0;
      ypos_bullet   <= '0;
      direction_out <= '0;
      target_hit    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      target_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            xpos_bullet   <= xpos_tank;
            ypos_bullet   <= ypos_tank;
            direction_out <= {1'b0, tank_dir} + 3'd1;
            state         <= FLY;
            busy          <= 1'b1;
          end
        end
        FLY: begin
          if (term) begin
            direction_out <= '0;
            target_hit    <= hit_now;
            if (COOLDOWN_FRAMES == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= COOLDOWN;
              cnt   <= CW'(COOLDOWN_FRAMES);
            end
          end else if (frame_tick) begin
            xpos_bullet <= nx[9:0];
            ypos_bullet <= ny[9:0];
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            cnt <= cnt - 1'b1;
            if (cnt <= CW'(1)) begin
              cnt   <= '0;
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          busy          <= 1'b0;
          direction_out <= '0;
        end
      endcase
    end
  end
endmodule
